// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end.
// FETCH_BOUNDS_CHECK_EN adds the FAULT state used for out-of-range fetches.
package fetch_pkg;

   localparam int unsigned IMEM_WORDS = 32;
   localparam int unsigned XLEN       = 32;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1
`ifdef FETCH_BOUNDS_CHECK_EN
      ,
      ST_FAULT = 2'd2
`endif
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic         full_o,
   output logic         empty_o,
   output fetch_entry_t head_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Sequential instruction fetch with redirect, halt and a small prefetch FIFO.
// FETCH_BOUNDS_CHECK_EN adds FetchFault and stops fetching past IMEM_WORDS.
module instruction_fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ImemReadEnable,
   output logic [31:0] ImemReadAddress,
   input  logic [31:0] ImemReadData,
   output logic        FetchValid,
   input  logic        FetchReady,
   output logic [31:0] FetchInstr,
   output logic [31:0] FetchPc,
   input  logic        RedirectValid,
   input  logic [31:0] RedirectPc,
   input  logic        HaltReq
`ifdef FETCH_BOUNDS_CHECK_EN
   ,
   output logic        FetchFault
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         rd_en;
   logic         push;
   logic         pop;
   logic         flush;
   logic         full;
   logic         empty;
   fetch_entry_t head;

   assign FetchValid      = !empty;
   assign FetchInstr      = head.instr;
   assign FetchPc         = head.pc;
   assign ImemReadAddress = {2'b00, pc_q[31:2]};
   assign ImemReadEnable  = rd_en && rst_n;
   assign pop             = FetchValid && FetchReady && !RedirectValid;
`ifdef FETCH_BOUNDS_CHECK_EN
   assign FetchFault      = (state_q == ST_FAULT);
`endif

   // Redirect wins over everything; otherwise RUN fetches whenever a slot frees up.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      rd_en   = 1'b0;
      push    = 1'b0;
      flush   = 1'b0;
      if (RedirectValid) begin
         flush   = 1'b1;
         pc_d    = RedirectPc & 32'hFFFF_FFFC;
         state_d = (state_q == ST_RUN || !HaltReq) ? ST_RUN : ST_HALT;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (HaltReq) begin
                  state_d = ST_HALT;
               end
               if (!full || pop) begin
`ifdef FETCH_BOUNDS_CHECK_EN
                  if (pc_q[31:2] >= 30'(IMEM_WORDS)) begin
                     state_d = ST_FAULT;
                  end else begin
                     rd_en = 1'b1;
                     push  = 1'b1;
                     pc_d  = pc_q + 32'd4;
                  end
`else
                  rd_en = 1'b1;
                  push  = 1'b1;
                  pc_d  = pc_q + 32'd4;
`endif
               end
            end
            ST_HALT: begin
               if (!HaltReq) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (fetch_entry_t'{pc: pc_q, instr: ImemReadData}),
      .pop_i       (pop),
      .flush_i     (flush),
      .full_o      (full),
      .empty_o     (empty),
      .head_o      (head)
   );

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed scenarios plus random traffic,
// with delivered instructions scored against the expected in-order PC stream.
module tb_instruction_fetch_controller;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        ImemReadEnable;
   logic [31:0] ImemReadAddress;
   logic [31:0] ImemReadData;
   logic        FetchValid;
   logic        FetchReady;
   logic [31:0] FetchInstr;
   logic [31:0] FetchPc;
   logic        RedirectValid;
   logic [31:0] RedirectPc;
   logic        HaltReq;
`ifdef FETCH_BOUNDS_CHECK_EN
   logic        FetchFault;
`endif

   instruction_fetch_controller #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ImemReadEnable  (ImemReadEnable),
      .ImemReadAddress (ImemReadAddress),
      .ImemReadData    (ImemReadData),
      .FetchValid      (FetchValid),
      .FetchReady      (FetchReady),
      .FetchInstr      (FetchInstr),
      .FetchPc         (FetchPc),
      .RedirectValid   (RedirectValid),
      .RedirectPc      (RedirectPc),
      .HaltReq         (HaltReq)
`ifdef FETCH_BOUNDS_CHECK_EN
      ,
      .FetchFault      (FetchFault)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_pc;
   int          total;
   int          bad;
   int          n_pops;

   function automatic logic [31:0] mem_word(input logic [31:0] widx);
      if (widx == 32'd0) return 32'h0000_0533;
      if (widx == 32'd1) return 32'h0010_0593;
      return widx * 32'h9E37_79B1 + 32'h0123_4567;
   endfunction

   always_comb ImemReadData = mem_word(ImemReadAddress);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Extend the expected stream: consecutive word-aligned PCs from the last flush point.
   function automatic void fill();
      exp_t e;
      while (exp_q.size() < 8) begin
`ifdef FETCH_BOUNDS_CHECK_EN
         if (model_pc[31:2] >= 30'd32) break;
`endif
         e.pc    = model_pc;
         e.instr = mem_word({2'b00, model_pc[31:2]});
         exp_q.push_back(e);
         model_pc = model_pc + 32'd4;
      end
   endfunction

   task automatic monitor();
      logic prev_flush;
      exp_t e;
      prev_flush = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_flush) check("flush_gap_valid", 32'(FetchValid), 32'd0);
         if (!rst_n) begin
            check("rst_read_enable", 32'(ImemReadEnable), 32'd0);
            exp_q.delete();
            model_pc   = RESET_PC;
            fill();
            prev_flush = 1'b1;
         end else if (RedirectValid) begin
            exp_q.delete();
            model_pc   = RedirectPc & 32'hFFFF_FFFC;
            fill();
            prev_flush = 1'b1;
         end else begin
            prev_flush = 1'b0;
            if (FetchValid && FetchReady) begin
               n_pops++;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_unexpected: got pc %h, expected no delivery", FetchPc);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_pc", FetchPc, e.pc);
                  check("sb_instr", FetchInstr, e.instr);
               end
               fill();
            end
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      n_pops = 0;
      model_pc = RESET_PC;
      rst_n = 1'b0;
      FetchReady = 1'b1;
      RedirectValid = 1'b0;
      RedirectPc = '0;
      HaltReq = 1'b0;
      fork
         monitor();
      join_none

      // reset values
      cyc();
      @(negedge clk);
      check("rst_valid", 32'(FetchValid), 32'd0);
      check("rst_instr", FetchInstr, 32'd0);
      check("rst_pc", FetchPc, 32'd0);
      check("rst_rden", 32'(ImemReadEnable), 32'd0);
`ifdef FETCH_BOUNDS_CHECK_EN
      check("rst_fault", 32'(FetchFault), 32'd0);
`endif
      cyc();
      rst_n = 1'b1;

      // first fetches after reset release
      @(negedge clk);
      check("first_rden", 32'(ImemReadEnable), 32'd1);
      check("first_addr", ImemReadAddress, 32'd0);
      cyc();
      @(negedge clk);
      check("c2_valid", 32'(FetchValid), 32'd1);
      check("c2_pc", FetchPc, 32'h0);
      check("c2_instr", FetchInstr, 32'h0000_0533);
      cyc();
      @(negedge clk);
      check("c3_pc", FetchPc, 32'h4);
      check("c3_instr", FetchInstr, 32'h0010_0593);
      cyc();

      // backpressure: FIFO fills to 2 and stops reading
      FetchReady = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check("full_rden", 32'(ImemReadEnable), 32'd0);
            check("full_valid", 32'(FetchValid), 32'd1);
         end
         cyc();
      end

      // redirect while full
      RedirectValid = 1'b1;
      RedirectPc    = 32'h0000_0012;
      @(negedge clk);
      check("redir_rden", 32'(ImemReadEnable), 32'd0);
      cyc();
      RedirectValid = 1'b0;
      FetchReady    = 1'b1;
      @(negedge clk);
      check("redir_gap", 32'(FetchValid), 32'd0);
      cyc();
      @(negedge clk);
      check("redir_valid", 32'(FetchValid), 32'd1);
      check("redir_pc", FetchPc, 32'h10);
      check("redir_instr", FetchInstr, mem_word(32'd4));
      cyc();

      // halt: reads stop, FIFO drains, then resume at held Pc
      HaltReq = 1'b1;
      for (int h = 1; h <= 4; h++) begin
         @(negedge clk);
         if (h >= 2) check("halt_rden", 32'(ImemReadEnable), 32'd0);
         if (h == 4) check("halt_drained", 32'(FetchValid), 32'd0);
         cyc();
      end
      HaltReq = 1'b0;
      cyc();
      @(negedge clk);
      check("resume_rden", 32'(ImemReadEnable), 32'd1);
      check("resume_addr", ImemReadAddress, 32'd7);
      cyc();

      // reset mid-stream with two entries queued
      FetchReady = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      FetchReady = 1'b1;
      @(negedge clk);
      check("midrst_valid", 32'(FetchValid), 32'd0);
      cyc();
      @(negedge clk);
      check("midrst_first_pc", FetchPc, RESET_PC);
      cyc();

      // Pc wrap at the top of the address space
      RedirectValid = 1'b1;
      RedirectPc    = 32'hFFFF_FFF9;
      cyc();
      RedirectValid = 1'b0;
      repeat (6) cyc();

`ifdef FETCH_BOUNDS_CHECK_EN
      // sequential fetch runs off the end of instruction memory
      RedirectValid = 1'b1;
      RedirectPc    = 32'h0000_0070;
      cyc();
      RedirectValid = 1'b0;
      repeat (10) cyc();
      @(negedge clk);
      check("fault_set", 32'(FetchFault), 32'd1);
      check("fault_rden", 32'(ImemReadEnable), 32'd0);
      check("fault_drained", 32'(FetchValid), 32'd0);
      check("fault_sb_empty", 32'(exp_q.size()), 32'd0);
      cyc();
      RedirectValid = 1'b1;
      RedirectPc    = 32'h0;
      cyc();
      RedirectValid = 1'b0;
      @(negedge clk);
      check("fault_clear", 32'(FetchFault), 32'd0);
      cyc();
      @(negedge clk);
      check("fault_resume_pc", FetchPc, 32'h0);
      cyc();
`endif

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         rst_n         = ($urandom % 100) != 0;
         FetchReady    = ($urandom % 4) != 0;
         RedirectValid = ($urandom % 24) == 0;
         if (($urandom % 8) == 0) RedirectPc = 32'hFFFF_FFF0 | ($urandom % 16);
         else                     RedirectPc = $urandom % 256;
         if (($urandom % 16) == 0) HaltReq = ~HaltReq;
         cyc();
      end

      // settle and drain
      rst_n = 1'b1;
      HaltReq = 1'b0;
      FetchReady = 1'b1;
      RedirectValid = 1'b1;
      RedirectPc = 32'h0;
      cyc();
      RedirectValid = 1'b0;
      repeat (20) cyc();
      total++;
      if (n_pops < 200) begin
         bad++;
         $display("FAIL delivery_volume: got %0d deliveries, required at least 200", n_pops);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 2: prefetch entries; power of 2, >=2.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  in  1: rising-edge clock.
REQ-005 SHALL have port rst_n  in  1: synchronous, active-low reset.
REQ-006 SHALL have port ImemReadEnable  out  1: read strobe to the instruction memory.
REQ-007 SHALL have port ImemReadAddress  out  32: word index, {2'b00, Pc[31:2]}.
REQ-008 SHALL have port ImemReadData  in  32: combinational read data, valid in the same cycle.
REQ-009 SHALL have port FetchValid  out  1: FIFO head holds an instruction.
REQ-010 SHALL have port FetchReady  in  1: decode accepts the head.
REQ-011 SHALL have port FetchInstr  out  32: head instruction word.
REQ-012 SHALL have port FetchPc  out  32: byte PC of the head instruction.
REQ-013 SHALL have port RedirectValid  in  1: branch or jump redirect strobe.
REQ-014 SHALL have port RedirectPc  in  32: redirect target; bits [1:0] are ignored and treated as 0.
REQ-015 SHALL have port HaltReq  in  1: level request to stop issuing new fetches.

Function
REQ-016 SHALL keep the internal Pc as a word-aligned byte address and increment it by 4 on each push.
REQ-017 SHALL implement FSM states RUN and HALT, plus FAULT when the macro is enabled.
REQ-018 In RUN with no redirect and (FIFO not full, or full with pop this cycle), SHALL drive ImemReadEnable=1 and push {Pc, ImemReadData}; otherwise ImemReadEnable=0.
REQ-019 SHALL make a pushed entry visible on FetchValid/FetchInstr/FetchPc on the next cycle (latency 1).
REQ-020 SHALL pop the head on FetchValid && FetchReady; simultaneous push and pop SHALL leave the count unchanged.
REQ-021 On RedirectValid, SHALL flush the FIFO, load Pc<=RedirectPc, and suppress the push and pop that cycle; redirect SHALL take priority over pop, push, HaltReq and FAULT.
REQ-022 After a redirect, FetchValid SHALL be 0 for 1 cycle, with the target instruction valid on the 2nd cycle.
REQ-023 RUN->HALT when HaltReq=1 and no redirect; in HALT, no reads are issued and the FIFO keeps draining.
REQ-024 HALT->RUN when HaltReq=0, resuming at the current Pc; a redirect in HALT SHALL load Pc, and the FSM goes to RUN only if HaltReq=0.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL never exceed FIFO_DEPTH or underflow.
REQ-026 Pc SHALL wrap 32'hFFFF_FFFC -> 0 with no side effect.

Reset
REQ-027 With rst_n=0 at a clock edge: Pc=RESET_PC, FIFO empty, state RUN, FetchValid=0, FetchInstr=0, FetchPc=0, FetchFault=0.
REQ-028 While rst_n=0, ImemReadEnable SHALL be 0; the first read SHALL occur in the first cycle with rst_n=1.
REQ-029 Reset asserted mid-stream SHALL discard all FIFO contents, with no partial pop.

Configuration
REQ-030 Macro FETCH_BOUNDS_CHECK_EN SHALL be supported.
REQ-031 When defined: adds output FetchFault (1 bit); a fetch with Pc[31:2] >= IMEM_WORDS SHALL NOT push, enters FAULT with FetchFault=1, and the FIFO drains; only a redirect or reset leaves FAULT.
REQ-032 When not defined: no FetchFault port, no FAULT state, and out-of-range addresses are issued unchecked.

Structure
REQ-033 Package fetch_pkg SHALL hold IMEM_WORDS=32, the FSM state enum, and the FIFO entry type {pc[31:0], instr[31:0]}.
REQ-034 Sub-module fetch_fifo SHALL hold the parameterised FIFO (push, pop, flush, full, empty, head); the FSM and Pc live in the top.

Verification
REQ-035 Reset release, FetchReady=1, memory word0=32'h00000533, word1=32'h00100593 -> cycle 2: FetchPc=0, FetchInstr=32'h00000533; cycle 3: FetchPc=4, FetchInstr=32'h00100593.
REQ-036 FetchReady=0 for 6 cycles with FIFO_DEPTH=2 -> count saturates at 2, ImemReadEnable=0 while full, no entry lost or duplicated after FetchReady=1.
REQ-037 RedirectValid=1, RedirectPc=32'h0000_0012 while the FIFO is full -> next cycle FetchValid=0; the following cycle FetchPc=32'h10 with instruction word 4.
REQ-038 HaltReq=1 for 4 cycles -> no ImemReadEnable, FIFO drains to empty; on HaltReq=0, fetch resumes at the held Pc.
REQ-039 FETCH_BOUNDS_CHECK_EN defined, sequential fetch reaching Pc=32'h80 -> FetchFault=1, last valid FetchPc=32'h7C; redirect to 0 -> FetchFault=0, fetch resumes at 0.
REQ-040 rst_n=0 for 1 cycle mid-stream with 2 entries queued -> FetchValid=0 next cycle; the first post-reset FetchPc equals RESET_PC.
